// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the multi-cycle ALU: queues {opt, A, B}, issues one op at a time, holds one result.
// Optional watchdog on the ALU wait enabled by defining ALU_TIMEOUT_EN (adds timeout_err).
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opt,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_opt,
    output logic                     alu_load,
    input  logic [WIDTH-1:0]         alu_dout,
    input  logic                     alu_done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [2:0]               res_opt,
    output logic                     busy
`ifdef ALU_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 3 + 2 * WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic          expire;

    // Pointers carry a wrap bit so full and empty stay distinguishable.
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign cmd_ready  = !full;
    assign fifo_count = wr_ptr - rd_ptr;
    assign busy       = (state != S_IDLE) || !empty;
    assign push       = cmd_valid && !full;
    assign pop        = (state == S_ISSUE);
    assign capture    = (state == S_WAIT) && alu_done;
    assign head       = mem[rd_ptr[AW-1:0]];

`ifdef ALU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;

    assign expire = (state == S_WAIT) && !alu_done && (wd_cnt == TW'(TIMEOUT - 1));

    // Watchdog counts WAIT cycles; it sits at zero outside WAIT so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != S_WAIT) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + TW'(1);
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_opt, cmd_a, cmd_b};
        end
    end

    // Issue only when the result slot is free or being emptied, so no result is overwritten.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (!empty && (!res_valid || res_ready)) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (alu_done || expire) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            alu_load  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_opt   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_opt   <= '0;
        end else begin
            state    <= state_d;
            alu_load <= (state_d == S_WAIT);
            if (push) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + CW'(1);
                alu_opt <= head[EW-1 -: 3];
                alu_a   <= head[2*WIDTH-1 -: WIDTH];
                alu_b   <= head[WIDTH-1:0];
            end
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= alu_dout;
                res_opt   <= alu_opt;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: emulates the ALU, keeps a queue-level model of FIFO and result slot, checks every cycle.
module tb_alu_cmd_sequencer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opt;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] fifo_count;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opt;
    logic       alu_load;
    logic [7:0] alu_dout;
    logic       alu_done;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_opt;
    logic       busy;
`ifdef ALU_TIMEOUT_EN
    logic       timeout_err;
`endif

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opt(cmd_opt), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .fifo_count(fifo_count),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opt(alu_opt), .alu_load(alu_load),
        .alu_dout(alu_dout), .alu_done(alu_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_opt(res_opt),
        .busy(busy)
`ifdef ALU_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Model state: queued commands {opt,a,b}, held results {opt,data}, op handed to the ALU.
    logic [18:0] mq[$];
    logic [10:0] rq[$];
    logic [7:0]  obs[$];
    logic [18:0] infl;
    bit          infl_v;
    int          cd;
    int          low_run;
    bit          prev_load, prev_rv;
    logic [7:0]  prev_rd;
    bit          ap_valid, ap_rready, ap_rst, ap_done_real;
    logic [18:0] ap_cmd;
    bit          last_push;
    bit          hold_done, spur_en;
    int          n_chk, n_err;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[2:0];
            3'd6:    return a >> b[2:0];
            default: return {7'd0, a < b};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the model for the edge just passed, compare, then drive the emulated ALU.
    task automatic step();
        bit do_push;
        @(negedge clk);
        ap_valid  = cmd_valid;
        ap_cmd    = {cmd_opt, cmd_a, cmd_b};
        ap_rready = res_ready;
        ap_rst    = rst;
        last_push = 0;
        if (ap_rst) begin
            mq.delete();
            rq.delete();
            infl_v  = 0;
            low_run = 100;
        end else begin
            if (prev_rv && ap_rready) obs.push_back(prev_rd);
            do_push = ap_valid && (mq.size() < DEPTH);
            if (ap_rready && rq.size() != 0) void'(rq.pop_front());
            if (ap_done_real) rq.push_back({infl[18:16], alu_fn(infl[18:16], infl[15:8], infl[7:0])});
            if (alu_load && !prev_load) begin
                check("issue_nonempty", 32'(mq.size() != 0), 1);
                check("issue_slot_free", 32'(rq.size()), 0);
                check("issue_spacing", 32'(low_run >= 3), 1);
                if (mq.size() != 0) infl = mq.pop_front();
                infl_v = 1;
                cd = $urandom_range(0, 3);
            end
            if (do_push) mq.push_back(ap_cmd);
            last_push = do_push;
        end
        low_run = alu_load ? 0 : low_run + 1;

        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
        check("res_valid", 32'(res_valid), 32'(rq.size() != 0));
        if (rq.size() != 0) begin
            check("res_data", 32'(res_data), 32'(rq[0][7:0]));
            check("res_opt", 32'(res_opt), 32'(rq[0][10:8]));
        end
        if (alu_load) begin
            check("alu_opt", 32'(alu_opt), 32'(infl[18:16]));
            check("alu_a", 32'(alu_a), 32'(infl[15:8]));
            check("alu_b", 32'(alu_b), 32'(infl[7:0]));
        end
        if (mq.size() != 0 || alu_load) check("busy_active", 32'(busy), 1);
        prev_load = alu_load;
        prev_rv   = res_valid;
        prev_rd   = res_data;

        ap_done_real = 0;
        if (alu_load && infl_v && !hold_done) begin
            if (cd == 0) begin
                alu_done     = 1'b1;
                alu_dout     = alu_fn(infl[18:16], infl[15:8], infl[7:0]);
                ap_done_real = 1;
            end else begin
                cd--;
                alu_done = 1'b0;
                alu_dout = 8'($urandom);
            end
        end else if (!alu_load && spur_en) begin
            alu_done = ($urandom_range(0, 3) == 0);
            alu_dout = 8'($urandom);
        end else begin
            alu_done = 1'b0;
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1; cmd_opt = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 200; i++) begin
            step();
            if (last_push) break;
        end
        check("push_accepted", 32'(last_push), 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!busy && !res_valid) break;
            step();
        end
        check("idle_reached", 32'(busy || res_valid), 0);
    endtask

    task automatic wait_load();
        for (int i = 0; i < 50; i++) begin
            if (alu_load) break;
            step();
        end
        check("load_seen", 32'(alu_load), 1);
    endtask

    logic [7:0] seq_exp [8] = '{8'd17, 8'd7, 8'd4, 8'd13, 8'd9, 8'd128, 8'd0, 8'd0};
    bit         found;

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opt = '0; cmd_a = '0; cmd_b = '0;
        res_ready = 1'b0; alu_done = 1'b0; alu_dout = '0;
        hold_done = 0; spur_en = 0; prev_load = 0; prev_rv = 0; prev_rd = '0;
        ap_done_real = 0; infl = '0; infl_v = 0; cd = 0; low_run = 100;

        repeat (3) step();
        check("rst_alu_load", 32'(alu_load), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_opt", 32'(alu_opt), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
`ifdef ALU_TIMEOUT_EN
        check("rst_timeout_err", 32'(timeout_err), 0);
`endif
        rst = 1'b0;
        repeat (2) step();

        // Single ADD: load rises two cycles after the push, falls the cycle after done.
        res_ready = 1'b1; spur_en = 1;
        cmd_valid = 1'b1; cmd_opt = 3'd0; cmd_a = 8'd12; cmd_b = 8'd5;
        step();
        cmd_valid = 1'b0;
        check("add_count_after_push", 32'(fifo_count), 1);
        check("add_load_t1", 32'(alu_load), 0);
        step();
        check("add_load_t2", 32'(alu_load), 0);
        step();
        check("add_load_t3", 32'(alu_load), 1);
        check("add_alu_a", 32'(alu_a), 12);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (alu_done && alu_load) begin
                step();
                check("add_load_fall", 32'(alu_load), 0);
                check("add_res_valid", 32'(res_valid), 1);
                check("add_res_data", 32'(res_data), 17);
                check("add_res_opt", 32'(res_opt), 0);
                found = 1;
            end else begin
                step();
            end
        end
        check("add_done_seen", 32'(found), 1);
        wait_idle();

        // All eight opcodes on A=12, B=5, results drained in order.
        obs.delete();
        for (int op = 0; op < 8; op++) push(3'(op), 8'd12, 8'd5);
        wait_idle();
        check("seq_count", 32'(obs.size()), 8);
        for (int i = 0; i < 8 && i < obs.size(); i++) check($sformatf("seq_res%0d", i), 32'(obs[i]), 32'(seq_exp[i]));

        // Backpressure: one result held, FIFO fills, the sixth push is dropped.
        res_ready = 1'b0; obs.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            cmd_valid = 1'b1; cmd_opt = 3'd0; cmd_a = 8'(i); cmd_b = 8'd100;
            step();
        end
        cmd_valid = 1'b0;
        repeat (20) step();
        check("bp_res_valid", 32'(res_valid), 1);
        check("bp_res_data", 32'(res_data), 100);
        check("bp_fifo_full", 32'(fifo_count), DEPTH);
        check("bp_cmd_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_opt = 3'd0; cmd_a = 8'd99; cmd_b = 8'd99;
        step();
        cmd_valid = 1'b0;
        check("bp_push_dropped", 32'(fifo_count), DEPTH);
        res_ready = 1'b1;
        wait_idle();
        check("bp_drain_count", 32'(obs.size()), DEPTH + 1);
        for (int i = 0; i < DEPTH + 1 && i < obs.size(); i++) check($sformatf("bp_drain%0d", i), 32'(obs[i]), 32'(100 + i));

        // Push lands on the same edge as the pop at count 1.
        cmd_valid = 1'b1; cmd_opt = 3'd2; cmd_a = 8'hF0; cmd_b = 8'h3C;
        step();
        cmd_valid = 1'b0;
        step();
        cmd_valid = 1'b1; cmd_opt = 3'd3;
        step();
        cmd_valid = 1'b0;
        check("pushpop_count", 32'(fifo_count), 1);
        check("pushpop_load", 32'(alu_load), 1);
        wait_idle();

        // Reset in WAIT abandons the op and the queue; late dones must not produce a result.
        hold_done = 1;
        push(3'd1, 8'd50, 8'd20);
        push(3'd4, 8'd1, 8'd2);
        push(3'd0, 8'd3, 8'd4);
        wait_load();
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0; hold_done = 0;
        check("midrst_load", 32'(alu_load), 0);
        check("midrst_res_valid", 32'(res_valid), 0);
        check("midrst_count", 32'(fifo_count), 0);
        check("midrst_cmd_ready", 32'(cmd_ready), 1);
        check("midrst_busy", 32'(busy), 0);
        alu_done = 1'b1; alu_dout = 8'hAA;
        repeat (15) step();
        check("midrst_no_stale", 32'(res_valid), 0);

        // Random traffic with stalls and spurious dones; pointers wrap many times.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_opt   = 3'($urandom);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cmd_valid = 1'b0; res_ready = 1'b1;
        wait_idle();

`ifdef ALU_TIMEOUT_EN
        // Watchdog: ALU never answers, WAIT ends after TIMEOUT cycles with no result.
        begin
            int cnt;
            hold_done = 1; spur_en = 0;
            check("to_err_before", 32'(timeout_err), 0);
            push(3'd0, 8'd1, 8'd2);
            push(3'd1, 8'd3, 8'd4);
            wait_load();
            cnt = 0;
            for (int i = 0; i < 200; i++) begin
                if (!alu_load) break;
                cnt++;
                step();
            end
            check("to_wait_len", 32'(cnt), TIMEOUT);
            check("to_err_set", 32'(timeout_err), 1);
            check("to_no_result", 32'(res_valid), 0);
            hold_done = 0;
            wait_load();
            wait_idle();
            check("to_err_sticky", 32'(timeout_err), 1);
        end
`endif

        check("final_busy", 32'(busy), 0);
        check("final_count", 32'(fifo_count), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream feeder for the low-area multi-cycle ALU.
- Buffers operation commands {opt, A, B} in a small FIFO, presents one command at a time to the ALU's A/B/opt/load inputs, and waits for the ALU's done.
- Captures Dout into a one-entry result register with a valid/ready handshake.
- Lets producers queue operations without tracking ALU latency.

Parameters:
- WIDTH, 8, operand and result width; matches the ALU width.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT, 64, watchdog limit in cycles; used only with ALU_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  FIFO not full.
- cmd_opt  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 SLT.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- fifo_count  out  clog2(DEPTH)+1  queued commands.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_opt  out  3  to ALU opt.
- alu_load  out  1  to ALU load.
- alu_dout  in  WIDTH  from ALU Dout.
- alu_done  in  1  from ALU done.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured Dout.
- res_opt  out  3  opcode that produced res_data.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset: clk rising edge with rst=1. Synchronous, active-high.
  - Clears FIFO pointers and count.
  - Forces FSM to IDLE.
  - Drives alu_load=0, alu_a/alu_b/alu_opt=0.
  - Clears res_valid=0, res_data=0, res_opt=0, busy=0.
  - fifo_count=0, cmd_ready=1.
  - Reset mid-operation abandons the in-flight ALU op; its result is never reported.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered-state based.
  - Read/write pointers carry an extra wrap bit: full = MSBs differ and LSBs equal.
  - Pop occurs on the ISSUE transition.
  - Simultaneous push and pop: count unchanged.
  - Push while full is ignored; the FIFO is not corrupted.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE: alu_load=0. If FIFO non-empty and (!res_valid, or res_ready this cycle) -> ISSUE.
  - ISSUE (1 cycle): pop the head entry into alu_a/alu_b/alu_opt registers; alu_load=1 -> WAIT.
  - WAIT: alu_load=1; operands held stable. When alu_done=1:
    - res_data <= alu_dout
    - res_opt <= alu_opt
    - res_valid <= 1
    - go to GAP
  - GAP (1 cycle): alu_load=0, so the ALU sees a load deassertion between ops -> IDLE.
- alu_done is sampled only in WAIT. A done asserted during ISSUE, GAP or IDLE is ignored.
- Result handshake:
  - res_valid clears on res_valid && res_ready, unless the same cycle captures a new result; in that case res_valid stays 1 with the new data.
  - A new op never issues while an unconsumed result would be overwritten, so no result is lost.
- Minimum command-to-command spacing is 3 cycles plus ALU latency.
- No arithmetic in this block. Widths pass through unchanged.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined:
  - Adds output port timeout_err (1 bit, reset 0) and a cycle counter that clears on WAIT entry.
  - If WAIT lasts TIMEOUT cycles without alu_done, the FSM goes to GAP and discards the op (no result).
  - timeout_err is set sticky; only rst clears it.
- Undefined:
  - No counter, no port; WAIT waits indefinitely.

Test Plan:
- ADD: push {000, 12, 5}, res_ready=1 -> alu_load rises 2 cycles after push, falls 1 cycle after done; res_data=17, res_opt=000.
- Sequence: push all 8 ops back-to-back with A=12, B=5 -> results in order 17, 7, 4, 13, 9, then ALU-defined SHL/SHR values, then 0 for SLT. alu_load is low for at least 1 cycle between ops.
- Backpressure and full FIFO:
  - res_ready=0; push DEPTH+2 commands -> one result held, DEPTH queued, cmd_ready=0, extra push dropped, fifo_count=DEPTH.
  - Raise res_ready -> all DEPTH+1 accepted results drain in order.
- Simultaneous push/pop at count=1 -> fifo_count stays 1. Pointer wrap after 2*DEPTH pushes -> data intact.
- Reset mid-op: assert rst during WAIT -> next cycle alu_load=0, res_valid=0, fifo_count=0, cmd_ready=1; no stale result appears after done.
- ALU_TIMEOUT_EN with alu_done tied 0, TIMEOUT=64 -> exit WAIT after 64 cycles, timeout_err=1, res_valid stays 0, next queued command issues.
